// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product channel: default widths, the
// accumulator-width rule, the FSM encoding and the output saturator.
package dot_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_FRAC_BITS = 8;

    // Working width of the saturator; every intermediate result fits in it.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Full-precision products plus growth for LANES*NUM_CHUNKS additions.
    function automatic int acc_w(input int data_w, input int lanes, input int chunks);
        return 2 * data_w + $clog2(lanes * chunks);
    endfunction

    // Clamp a signed value into the range of a w-bit two's-complement number.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                    input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/dot_lane_tree.sv
// LANES signed multipliers followed by a registered adder tree.
// Fixed two-cycle latency: products at p1, lane sum at p2.
module dot_lane_tree
    import dot_pkg::*;
#(
    parameter int LANES  = 288,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vld_p0,
    input  logic [LANES*DATA_W-1:0]  d_p0,
    input  logic [LANES*DATA_W-1:0]  w_p0,
    output logic                     vld_p2,
    output logic signed [ACC_W-1:0]  sum_p2
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0]    prod_p1_d [LANES];
    logic signed [PW-1:0]    prod_p1_q [LANES];
    logic                    vld_p1_d;
    logic                    vld_p1_q;
    logic signed [ACC_W-1:0] sum_p2_d;
    logic signed [ACC_W-1:0] sum_p2_q;
    logic                    vld_p2_d;
    logic                    vld_p2_q;

    // Stage p0 -> p1: one full-precision signed multiply per lane.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_p1_d[i] = PW'($signed(d_p0[i*DATA_W +: DATA_W])) *
                           PW'($signed(w_p0[i*DATA_W +: DATA_W]));
        end
        vld_p1_d = vld_p0;
    end

    // Stage p1 -> p2: sum all lanes, sign-extended to the accumulator width.
    always_comb begin
        sum_p2_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_p2_d = sum_p2_d + ACC_W'(prod_p1_q[i]);
        end
        vld_p2_d = vld_p1_q;
    end

    // Pipeline registers; only the valid bits are reset.
    always_ff @(posedge clk) begin
        prod_p1_q <= prod_p1_d;
        sum_p2_q  <= sum_p2_d;
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    assign vld_p2 = vld_p2_q;
    assign sum_p2 = sum_p2_q;

endmodule

// File: rtl/dot_channel_acc.sv
// One output neuron: streams NUM_CHUNKS beats of LANES elements against a
// weight set from the on-chip ROM, adds the set bias, optional ReLU,
// saturates to DATA_W and hands the result out on a valid/ready port.
// The ROM contents are elaborated from the WEIGHTS / BIASES parameter vectors
// (set-major, then chunk, then lane; lane 0 in the least significant bits).
module dot_channel_acc
    import dot_pkg::*;
#(
    parameter int LANES      = 288,
    parameter int NUM_CHUNKS = 12,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_W      = acc_w(DATA_W, LANES, NUM_CHUNKS),
    parameter int WSETS      = 16,
    parameter int WSEL_W     = (WSETS > 1) ? $clog2(WSETS) : 1,
    parameter logic [WSETS*NUM_CHUNKS*LANES*DATA_W-1:0] WEIGHTS = '0,
    parameter logic [WSETS*DATA_W-1:0]                  BIASES  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WSEL_W-1:0]       wsel,
    input  logic                    relu_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] d,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       q,
    output logic                    busy
);

    localparam int ROW_W   = LANES * DATA_W;
    localparam int CHUNK_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int RW      = ACC_W + 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);
    localparam logic [WSEL_W:0]    WSETS_C    = (WSEL_W + 1)'(WSETS);

    state_t                  state_q, state_d;
    logic [CHUNK_W-1:0]      chunk_q, chunk_d;
    logic [1:0]              flush_q, flush_d;
    logic [WSEL_W-1:0]       set_q, set_d;
    logic                    relu_q, relu_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]       q_q, q_d;

    logic                    accept;
    logic                    wsel_ok;
    logic [ROW_W-1:0]        w_row;
    logic signed [DATA_W-1:0] bias;
    logic                    tree_vld;
    logic signed [ACC_W-1:0] tree_sum;

    // Bias alignment, floor shift back to the data format, ReLU, saturation.
    function automatic logic [DATA_W-1:0] finish(input logic signed [ACC_W-1:0]  acc,
                                                 input logic signed [DATA_W-1:0] b,
                                                 input logic                     relu);
        logic signed [RW-1:0]    biased;
        logic signed [RW-1:0]    shifted;
        logic signed [SAT_W-1:0] wide;
        biased  = RW'(acc) + (RW'(b) <<< FRAC_BITS);
        shifted = biased >>> FRAC_BITS;
        if (relu && shifted[RW-1]) shifted = '0;
        wide = SAT_W'(shifted);
        return DATA_W'(sat(wide, DATA_W));
    endfunction

    assign accept  = (state_q == S_ACCUM) && in_valid;
    assign wsel_ok = ({1'b0, wsel} < WSETS_C);

    // Weight row and bias lookup for the latched set and current chunk.
    always_comb begin
        w_row = WEIGHTS[(int'(set_q) * NUM_CHUNKS + int'(chunk_q)) * ROW_W +: ROW_W];
        bias  = BIASES[int'(set_q) * DATA_W +: DATA_W];
    end

    dot_lane_tree #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_tree (
        .clk    (clk),
        .rst    (rst),
        .vld_p0 (accept),
        .d_p0   (d),
        .w_p0   (w_row),
        .vld_p2 (tree_vld),
        .sum_p2 (tree_sum)
    );

    // Control FSM: operand latching, chunk counting and the flush timer.
    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        flush_d = flush_q;
        set_d   = set_q;
        relu_d  = relu_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    set_d   = wsel_ok ? wsel : '0;
                    relu_d  = relu_en;
                    chunk_d = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    if (chunk_q == LAST_CHUNK) begin
                        chunk_d = '0;
                        flush_d = '0;
                        state_d = S_FLUSH;
                    end else begin
                        chunk_d = chunk_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == 2'd2) begin
                    state_d = S_OUT;
                end else begin
                    flush_d = flush_q + 2'd1;
                end
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Accumulate lane sums as they leave the tree; finalize on the last flush cycle.
    always_comb begin
        acc_d = acc_q;
        if (state_q == S_IDLE && start) begin
            acc_d = '0;
        end else if (tree_vld) begin
            acc_d = acc_q + tree_sum;
        end
        q_d = q_q;
        if (state_q == S_FLUSH && flush_q == 2'd2) begin
            q_d = finish(acc_q, bias, relu_q);
        end
    end

    // State, accumulator and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            chunk_q <= '0;
            flush_q <= '0;
            set_q   <= '0;
            relu_q  <= 1'b0;
            acc_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            flush_q <= flush_d;
            set_q   <= set_d;
            relu_q  <= relu_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign q         = q_q;

    a_wsel_range: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_IDLE && start) |-> wsel_ok)
        else $error("dot_channel_acc: wsel out of range, set 0 used");

endmodule
